// File: rtl/ibus_line_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ibus_line_buffer_if
// Brief    : Fetch-side (ibus) and memory-side (cbus) signal bundle for the
//            single-line instruction buffer.
// Revision : 1.0
// ============================================================================
interface ibus_line_buffer_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;

    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;

    logic        creq_valid;
    logic        creq_is_write;
    logic [2:0]  creq_size;
    logic [63:0] creq_addr;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic [3:0]  creq_len;
    logic [1:0]  creq_burst;

    logic        cresp_ready;
    logic        cresp_last;
    logic [63:0] cresp_data;

    modport slave (
        input  ireq_valid, ireq_addr,
        input  cresp_ready, cresp_last, cresp_data,
        output iresp_addr_ok, iresp_data_ok, iresp_data,
        output creq_valid, creq_is_write, creq_size, creq_addr,
        output creq_strobe, creq_data, creq_len, creq_burst
    );

    modport master (
        output ireq_valid, ireq_addr,
        output cresp_ready, cresp_last, cresp_data,
        input  iresp_addr_ok, iresp_data_ok, iresp_data,
        input  creq_valid, creq_is_write, creq_size, creq_addr,
        input  creq_strobe, creq_data, creq_len, creq_burst
    );
endinterface
`default_nettype wire

// File: rtl/ibus_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ibus_line_buffer
// Brief    : Single-line instruction buffer; hits answer combinationally,
//            misses refill the whole line with one incrementing burst.
// Revision : 1.0
// ============================================================================
module ibus_line_buffer #(
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    ibus_line_buffer_if.slave bus
);

    localparam int         c_off_w      = $clog2(LINE_WORDS * 8);
    localparam int         c_beat_w     = $clog2(LINE_WORDS);
    localparam int         c_tag_w      = 64 - c_off_w;
    localparam logic [2:0] c_msize8     = 3'd3;
    localparam logic [1:0] c_burst_incr = 2'b01;
    localparam logic [3:0] c_len        = 4'(LINE_WORDS - 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_fill = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [63:0]         r_line [LINE_WORDS];
    logic [c_tag_w-1:0]  r_tag;
    logic [c_tag_w-1:0]  r_fill_tag;
    logic                r_lvalid;
    logic                r_kill;
    logic [c_beat_w-1:0] r_beat;

    logic [c_tag_w-1:0]  w_req_tag;
    logic [c_beat_w-1:0] w_off;
    logic                w_half;
    logic [63:0]         w_word;
    logic                w_idle;
    logic                w_fill;
    logic                w_hit;
    logic                w_miss;
    logic                w_unused;

    assign w_req_tag = bus.ireq_addr[63:c_off_w];
    assign w_off     = bus.ireq_addr[c_off_w-1:3];
    assign w_half    = bus.ireq_addr[2];
    assign w_word    = r_line[w_off];
    assign w_unused  = &{1'b0, bus.ireq_addr[1:0]};

    assign w_idle = (r_state == c_st_idle);
    assign w_fill = (r_state == c_st_fill);
    assign w_hit  = w_idle && bus.ireq_valid && r_lvalid && (r_tag == w_req_tag) && !flush;
    assign w_miss = w_idle && bus.ireq_valid && !w_hit && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_miss) w_state_next = c_st_fill;
            c_st_fill: if (bus.cresp_ready && bus.cresp_last) w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_line[i] <= '0;
            end
            r_tag      <= '0;
            r_fill_tag <= '0;
            r_lvalid   <= 1'b0;
            r_kill     <= 1'b0;
            r_beat     <= '0;
        end else if (w_idle) begin
            if (flush) begin
                r_lvalid <= 1'b0;
            end
            if (w_miss) begin
                r_fill_tag <= w_req_tag;
                r_beat     <= '0;
                r_kill     <= 1'b0;
            end
        end else begin
            // A flush anywhere in the burst, including the last beat, voids the install.
            if (flush) begin
                r_kill <= 1'b1;
            end
            if (bus.cresp_ready) begin
                r_line[r_beat] <= bus.cresp_data;
                r_beat         <= r_beat + c_beat_w'(1);
                if (bus.cresp_last) begin
                    r_tag    <= r_fill_tag;
                    r_lvalid <= !r_kill && !flush;
                end
            end
        end
    end

    assign bus.iresp_addr_ok = w_hit;
    assign bus.iresp_data_ok = w_hit;
    assign bus.iresp_data    = w_half ? w_word[63:32] : w_word[31:0];

    // The memory request is a pure function of registers, never of cresp.
    assign bus.creq_valid    = w_fill;
    assign bus.creq_is_write = 1'b0;
    assign bus.creq_size     = w_fill ? c_msize8 : 3'd0;
    assign bus.creq_addr     = w_fill ? {r_fill_tag, {c_off_w{1'b0}}} : 64'd0;
    assign bus.creq_strobe   = 8'd0;
    assign bus.creq_data     = 64'd0;
    assign bus.creq_len      = w_fill ? c_len : 4'd0;
    assign bus.creq_burst    = w_fill ? c_burst_incr : 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_ibus_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ibus_line_buffer
// Brief    : Self-checking bench; memory answers from an address function and
//            expected fetch data is derived from that same function.
// Revision : 1.0
// ============================================================================
module tb_ibus_line_buffer;

    localparam int LW = 4;
    localparam int LB = LW * 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    int          total = 0;
    int          bad = 0;
    logic [31:0] salt = '0;
    bit          stall_mode = 1'b0;
    bit          m_valid = 1'b0;
    logic [63:0] m_base = '0;
    int          mcnt = 0;
    int          phase = 0;
    int          bursts_done = 0;
    bit          in_burst = 1'b0;
    logic [63:0] burst_q[$];

    ibus_line_buffer_if bus();

    ibus_line_buffer #(.LINE_WORDS(LW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] line_base(input logic [63:0] a);
        return a & ~64'(LB - 1);
    endfunction

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [31:0] r;
        r = a[31:0] - 32'h8000_0000;
        return {(32'h1111_0000 + r) ^ salt, (32'h2222_0000 + r) ^ {salt[15:0], salt[31:16]}};
    endfunction

    function automatic logic [31:0] exp_word(input logic [63:0] a);
        logic [63:0] w;
        w = mem_word({a[63:3], 3'b000});
        return a[2] ? w[63:32] : w[31:0];
    endfunction

    function automatic logic [63:0] new_base();
        logic [63:0] b;
        b = 64'h8000_0000 + 64'($urandom_range(1, 1000)) * 64'(LB);
        if (b == m_base || b == 64'h8000_0100) b = b + 64'(2 * LB);
        return b;
    endfunction

    // Memory slave: drives beats on the falling edge, accepted on the next rising edge.
    initial begin : mem_model
        logic [145:0] got_f;
        logic [145:0] exp_f;
        bit           rdy;
        bus.cresp_ready = 1'b0;
        bus.cresp_last  = 1'b0;
        bus.cresp_data  = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mcnt = 0; in_burst = 1'b0;
                bus.cresp_ready = 1'b0; bus.cresp_last = 1'b0;
            end else begin
                if (in_burst && !bus.creq_valid) begin
                    total++; bad++;
                    $display("FAIL creq_valid_hold: actual 0 required 1 (beat %0d)", mcnt);
                    in_burst = 1'b0; mcnt = 0;
                end
                if (bus.creq_valid) begin
                    if (!in_burst) begin
                        in_burst = 1'b1; phase = 0;
                        burst_q.push_back(bus.creq_addr);
                    end
                    got_f = {bus.creq_is_write, bus.creq_size, bus.creq_len, bus.creq_burst,
                             bus.creq_strobe, bus.creq_data, bus.creq_addr & 64'(LB - 1)};
                    exp_f = {1'b0, 3'd3, 4'(LW - 1), 2'd1, 8'd0, 64'd0, 64'd0};
                    total++;
                    if (got_f !== exp_f) begin
                        bad++;
                        $display("FAIL creq_fields: actual %h required %h", got_f, exp_f);
                    end
                    rdy = stall_mode ? (phase % 3 == 2) : 1'b1;
                    phase++;
                    if (rdy) begin
                        bus.cresp_ready = 1'b1;
                        bus.cresp_data  = mem_word(bus.creq_addr + 64'(mcnt * 8));
                        bus.cresp_last  = (mcnt == LW - 1);
                        if (mcnt == LW - 1) begin
                            in_burst = 1'b0; mcnt = 0; bursts_done++;
                        end else begin
                            mcnt++;
                        end
                    end else begin
                        bus.cresp_ready = 1'b0;
                        bus.cresp_last  = 1'b0;
                        bus.cresp_data  = {$urandom, $urandom};
                    end
                end else begin
                    bus.cresp_ready = 1'b0;
                    bus.cresp_last  = 1'b0;
                    total++;
                    if ({bus.creq_is_write, bus.creq_size, bus.creq_addr, bus.creq_strobe,
                         bus.creq_data, bus.creq_len, bus.creq_burst} !== '0) begin
                        bad++;
                        $display("FAIL creq_idle_zero: actual addr=%h len=%0d required 0",
                                 bus.creq_addr, bus.creq_len);
                    end
                end
            end
        end
    end

    task automatic do_fetch(input logic [63:0] a, input string nm, output int lat);
        bit          exp_hit;
        bit          seen;
        logic [31:0] exp;
        int          n;
        exp_hit = m_valid && (line_base(a) == m_base);
        exp     = exp_word(a);
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = a;
        @(negedge clk);
        total++;
        if ({bus.iresp_addr_ok, bus.iresp_data_ok} !== {exp_hit, exp_hit}) begin
            bad++;
            $display("FAIL %s_first: addr_ok/data_ok actual %b%b required %b%b", nm,
                     bus.iresp_addr_ok, bus.iresp_data_ok, exp_hit, exp_hit);
        end
        n = 0;
        seen = exp_hit;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            total++;
            if (bus.iresp_data_ok === 1'b1 && bus.creq_valid === 1'b1) begin
                bad++;
                $display("FAIL %s_ok_in_fill: data_ok actual 1 required 0", nm);
            end
            if (bus.iresp_data_ok === 1'b1) seen = 1'b1;
        end
        lat = n;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_timeout: data_ok actual 0 required 1", nm);
        end
        if (!exp_hit) begin
            m_valid = 1'b1;
            m_base  = line_base(a);
        end
        total++;
        if (bus.iresp_data !== exp) begin
            bad++;
            $display("FAIL %s_data: actual %h required %h", nm, bus.iresp_data, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        total++;
        if (bus.iresp_data_ok !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_resp: data_ok actual %b required 0", bus.iresp_data_ok);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        flush  = 1'b0;
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 64'h8000_0004;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.iresp_addr_ok, bus.iresp_data_ok, bus.iresp_data} !== 34'd0) begin
            bad++;
            $display("FAIL reset_iresp: actual %b%b %h required 0", bus.iresp_addr_ok,
                     bus.iresp_data_ok, bus.iresp_data);
        end
        total++;
        if ({bus.creq_valid, bus.creq_addr, bus.creq_len} !== '0) begin
            bad++;
            $display("FAIL reset_creq: valid=%b addr=%h required 0", bus.creq_valid, bus.creq_addr);
        end
        bus.ireq_valid = 1'b0;
        @(posedge clk); #2 resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss();
        int lat;
        salt = '0;
        do_fetch(64'h8000_0004, "cold", lat);
        total++;
        if (lat != LW + 1) begin
            bad++;
            $display("FAIL cold_latency: actual %0d required %0d", lat, LW + 1);
        end
        total++;
        if (bus.iresp_data !== 32'h1111_0000) begin
            bad++;
            $display("FAIL cold_const: actual %h required 11110000", bus.iresp_data);
        end
        total++;
        if (burst_q.size() != 1 || burst_q[0] !== 64'h8000_0000) begin
            bad++;
            $display("FAIL cold_creq_addr: bursts=%0d required 1 at 80000000", burst_q.size());
        end
    endtask

    task automatic test_seq_hits();
        int  lat;
        int  b0;
        time t0;
        b0 = bursts_done;
        t0 = $time;
        for (int i = 0; i < 8; i++) begin
            do_fetch(64'h8000_0000 + 64'(4 * i), "seq", lat);
        end
        total++;
        if (($time - t0) != 80 || bursts_done != b0) begin
            bad++;
            $display("FAIL seq_rate: actual %0t ns / %0d bursts required 80 ns / 0 bursts",
                     $time - t0, bursts_done - b0);
        end
    endtask

    task automatic test_stall_miss();
        logic [63:0] b;
        int          lat;
        int          order[8];
        salt = $urandom;
        pulse_flush();
        stall_mode = 1'b1;
        b = new_base();
        do_fetch(b + 64'(4 * $urandom_range(0, 7)), "stall", lat);
        stall_mode = 1'b0;
        for (int i = 0; i < 8; i++) order[i] = i;
        order.shuffle();
        for (int i = 0; i < 8; i++) begin
            do_fetch(b + 64'(4 * order[i]), "stall_hit", lat);
        end
    endtask

    task automatic test_flush_fill();
        logic [63:0] b;
        int          n;
        int          b0;
        int          q0;
        bit          seen;
        bit          flushed;
        b  = new_base();
        b0 = bursts_done;
        q0 = burst_q.size();
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = b + 64'd12;
        n = 0; seen = 1'b0; flushed = 1'b0;
        while (!seen && n < 300) begin
            @(posedge clk); #1;
            flush = 1'b0;
            if (!flushed && mcnt == 2) begin
                flush = 1'b1; flushed = 1'b1;
            end
            @(negedge clk);
            n++;
            if (bus.iresp_data_ok === 1'b1) seen = 1'b1;
        end
        flush = 1'b0;
        total++;
        if (!seen || bursts_done != b0 + 2) begin
            bad++;
            $display("FAIL flush_fill_refetch: seen=%b bursts=%0d required 1 / 2", seen,
                     bursts_done - b0);
        end
        total++;
        if (burst_q.size() < q0 + 2 || burst_q[q0] !== b || burst_q[q0 + 1] !== b) begin
            bad++;
            $display("FAIL flush_fill_addr: bursts=%0d required two at %h", burst_q.size() - q0, b);
        end
        total++;
        if (bus.iresp_data !== exp_word(b + 64'd12)) begin
            bad++;
            $display("FAIL flush_fill_data: actual %h required %h", bus.iresp_data,
                     exp_word(b + 64'd12));
        end
        m_valid = 1'b1;
        m_base  = b;
        @(posedge clk); #1;
    endtask

    task automatic test_redirect();
        logic [63:0] a;
        logic [63:0] b;
        int          n;
        int          b0;
        int          q0;
        int          gap;
        bit          seen;
        bit          switched;
        pulse_flush();
        a  = new_base();
        b  = 64'h8000_0100;
        b0 = bursts_done;
        q0 = burst_q.size();
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = a + 64'd8;
        n = 0; gap = 0; seen = 1'b0; switched = 1'b0;
        while (!seen && n < 300) begin
            @(posedge clk); #1;
            if (!switched && mcnt >= 2) begin
                bus.ireq_addr = b + 64'd4;
                switched = 1'b1;
            end
            @(negedge clk);
            n++;
            if (bursts_done == b0 + 1 && !bus.creq_valid) gap++;
            if (bus.iresp_data_ok === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || gap != 1) begin
            bad++;
            $display("FAIL redirect_gap: seen=%b idle cycles actual %0d required 1", seen, gap);
        end
        total++;
        if (burst_q.size() < q0 + 2 || burst_q[q0] !== a || burst_q[q0 + 1] !== b) begin
            bad++;
            $display("FAIL redirect_addr: bursts=%0d required %h then %h", burst_q.size() - q0, a, b);
        end
        total++;
        if (bus.iresp_data !== exp_word(b + 64'd4)) begin
            bad++;
            $display("FAIL redirect_data: actual %h required %h", bus.iresp_data, exp_word(b + 64'd4));
        end
        m_valid = 1'b1;
        m_base  = b;
        @(posedge clk); #1;
    endtask

    task automatic test_drop_valid();
        logic [63:0] d;
        int          n;
        int          b0;
        int          lat;
        d  = new_base();
        b0 = bursts_done;
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = d;
        @(posedge clk); #1;
        bus.ireq_valid = 1'b0;
        bus.ireq_addr  = {$urandom, $urandom};
        n = 0;
        while (bursts_done < b0 + 1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bursts_done != b0 + 1) begin
            bad++;
            $display("FAIL drop_valid_fill: bursts actual %0d required 1", bursts_done - b0);
        end
        @(posedge clk); #1;
        m_valid = 1'b1;
        m_base  = d;
        do_fetch(d + 64'(4 * $urandom_range(0, 7)), "drop_valid_hit", lat);
    endtask

    task automatic test_reset_mid();
        logic [63:0] c;
        logic [63:0] prev;
        int          n;
        int          lat;
        prev = m_base;
        c    = new_base();
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = c;
        n = 0;
        while (mcnt != 2 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        #2 resetn = 1'b0;
        #1;
        total++;
        if (bus.creq_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_creq: valid actual %b required 0", bus.creq_valid);
        end
        total++;
        if ({bus.iresp_addr_ok, bus.iresp_data_ok, bus.iresp_data} !== 34'd0) begin
            bad++;
            $display("FAIL reset_mid_iresp: actual %b%b %h required 0", bus.iresp_addr_ok,
                     bus.iresp_data_ok, bus.iresp_data);
        end
        bus.ireq_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2 resetn = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0;
        do_fetch(prev + 64'd8, "after_reset", lat);
    endtask

    task automatic test_random();
        logic [63:0] lines[3];
        int          lat;
        for (int i = 0; i < 3; i++) lines[i] = 64'h8000_0000 + 64'(LB * (2000 + 7 * i));
        for (int i = 0; i < 40; i++) begin
            stall_mode = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin
                pulse_flush();
            end else begin
                do_fetch(lines[$urandom_range(0, 2)] + 64'(4 * $urandom_range(0, 7)), "rand", lat);
            end
        end
        stall_mode = 1'b0;
    endtask

    initial begin : main
        bus.ireq_valid = 1'b0;
        bus.ireq_addr  = '0;
        flush  = 1'b0;
        resetn = 1'b0;
        test_reset();
        test_cold_miss();
        test_seq_hits();
        test_stall_miss();
        test_flush_fill();
        test_redirect();
        test_drop_valid();
        test_reset_mid();
        test_random();
        bus.ireq_valid = 1'b0;
        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
